// File: rtl/mux_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mux_rr_arbiter
//   Round-robin arbiter that owns the select of a 4:1 single-bit mux. Four
//   requesters share the mux path. The registered one-hot grant goes back to
//   the requesters, and the data bit of the granted requester appears on
//   y_out.
//
//   Optional feature: define ARB_TIMEOUT_EN to enable a hold-time limit. A
//   requester that has held the grant for MAX_HOLD cycles is then released
//   by force, and timeout_out pulses for one cycle. When the macro is
//   undefined, a holder keeps the grant for as long as it requests, and
//   timeout_out stays 0.
//
// Parameters
//   MAX_HOLD    - maximum consecutive grant cycles per holder (>= 2), used
//                 only when ARB_TIMEOUT_EN is defined
//   CNT_W       - hold counter width, 2**CNT_W >= MAX_HOLD
//
// Ports
//   clk_in      - clock, rising edge
//   rst_in      - synchronous active-high reset
//   req_in[3:0] - level-sensitive requests, bit i = requester i
//   data_in[3:0]- mux data inputs, bit i = requester i
//   gnt_out     - registered one-hot grant, zero when idle
//   sel_out     - registered mux select (index of holder), kept while idle
//   valid_out   - a grant is active (== |gnt_out)
//   y_out       - combinational mux output, forced 0 when not valid
//   timeout_out - one-cycle pulse on a forced release
// ---------------------------------------------------------------------------
module mux_rr_arbiter #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic [3:0] req_in,
    input  logic [3:0] data_in,
    output logic [3:0] gnt_out,
    output logic [1:0] sel_out,
    output logic       valid_out,
    output logic       y_out,
    output logic       timeout_out
);

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_GRANT = 1'b1;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    logic             state_q, state_d;
    logic [1:0]       ptr_q,   ptr_d;
    logic [1:0]       sel_q,   sel_d;
    logic [3:0]       gnt_q,   gnt_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             to_q,    to_d;

    // Round-robin pick: the first set bit at or after ptr, wrapping mod 4.
    // The result is {found, index}. The loop scans from the farthest
    // position to the nearest, so the nearest set bit is written last and
    // wins.
    function automatic logic [2:0] rr_pick(input logic [3:0] req,
                                           input logic [1:0] ptr);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (req[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    logic       hold_req;
    logic [1:0] ptr_nxt;
    logic [3:0] hold_mask;
    logic [3:0] others;
    logic [2:0] pick_idle;
    logic [2:0] pick_hand;
    logic       hold_expire;

    assign hold_req  = req_in[sel_q];
    assign ptr_nxt   = sel_q + 2'd1;
    assign hold_mask = 4'b0001 << sel_q;

    // The holder is masked out of the handover arbitration. On a normal
    // release its request is already 0, so the mask changes nothing. On a
    // forced release the mask lets the other requesters win, and the holder
    // is granted again only when none of them is pending.
    assign others    = req_in & ~hold_mask;
    assign pick_idle = rr_pick(req_in, ptr_q);
    assign pick_hand = rr_pick(others, ptr_nxt);

`ifdef ARB_TIMEOUT_EN
    assign hold_expire = (cnt_q == HOLD_LAST);
`else
    assign hold_expire = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        gnt_d   = gnt_q;
        cnt_d   = cnt_q;
        to_d    = 1'b0;

        if (state_q == ST_IDLE) begin
            if (pick_idle[2]) begin
                state_d = ST_GRANT;
                sel_d   = pick_idle[1:0];
                gnt_d   = 4'b0001 << pick_idle[1:0];
                cnt_d   = '0;
            end
        end else begin
            if (!hold_req || hold_expire) begin
                // Release, normal or forced. The pointer moves past the
                // holder, and arbitration runs on this same edge, so a
                // handover leaves no idle gap.
                ptr_d = ptr_nxt;
                // The holder still requesting here means the release was
                // forced.
                to_d  = hold_req;
                if (pick_hand[2]) begin
                    sel_d = pick_hand[1:0];
                    gnt_d = 4'b0001 << pick_hand[1:0];
                    cnt_d = '0;
                end else if (hold_req) begin
                    // Forced release with nobody else waiting: re-grant
                    // the holder. gnt stays high without a break.
                    cnt_d = '0;
                end else begin
                    state_d = ST_IDLE;
                    gnt_d   = 4'b0000;
                end
            end else if (cnt_q != HOLD_LAST) begin
                // The counter saturates instead of wrapping, so a long hold
                // with the limit disabled never looks like a fresh grant.
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= ST_IDLE;
            ptr_q   <= 2'd0;
            sel_q   <= 2'd0;
            gnt_q   <= 4'b0000;
            cnt_q   <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
            to_q    <= to_d;
        end
    end

    assign gnt_out     = gnt_q;
    assign sel_out     = sel_q;
    assign valid_out   = |gnt_q;
    // sel_q keeps its last value while idle, so valid_out gates the mux.
    assign y_out       = valid_out & data_in[sel_q];
    assign timeout_out = to_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Testbench for mux_rr_arbiter. It drives directed request/data vectors and
// uses two kinds of checks. A round-robin model at the arbitration level is
// compared against every output on each falling edge. Hand-computed literal
// expectations at fixed points pin down both the DUT and the model.
module tb_mux_rr_arbiter;

    localparam int MAX_HOLD = 8;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk_in  = 1'b0;
    logic       rst_in  = 1'b1;
    logic [3:0] req_in  = 4'b0000;
    logic [3:0] data_in = 4'b0000;
    logic [3:0] gnt_out;
    logic [1:0] sel_out;
    logic       valid_out;
    logic       y_out;
    logic       timeout_out;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    always #5 clk_in = ~clk_in;

    mux_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(4)) dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .req_in      (req_in),
        .data_in     (data_in),
        .gnt_out     (gnt_out),
        .sel_out     (sel_out),
        .valid_out   (valid_out),
        .y_out       (y_out),
        .timeout_out (timeout_out)
    );

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int m_h   = -1;   // index of the current holder, -1 when idle
    int m_ptr = 0;
    int m_cnt = 0;    // number of grant cycles completed by the holder
    int m_sel = 0;
    bit m_to  = 1'b0;

    function automatic int pick(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    always @(posedge clk_in) begin : model
        int nh, nptr, ncnt, nsel, w;
        bit nto;
        logic [3:0] r;
        nh = m_h; nptr = m_ptr; ncnt = m_cnt; nsel = m_sel; nto = 1'b0;
        if (rst_in) begin
            nh = -1; nptr = 0; ncnt = 0; nsel = 0;
        end else if (nh < 0) begin
            w = pick(req_in, nptr);
            if (w >= 0) begin nh = w; nsel = w; ncnt = 0; end
        end else if (!req_in[nh]) begin
            nptr = (nh + 1) % 4;
            w = pick(req_in, nptr);
            if (w >= 0) begin nh = w; nsel = w; ncnt = 0; end
            else nh = -1;
        end else if (TO_EN && ncnt == MAX_HOLD - 1) begin
            nptr = (nh + 1) % 4;
            nto = 1'b1;
            r = req_in;
            r[nh] = 1'b0;
            w = pick(r, nptr);
            if (w < 0) w = nh;
            nh = w; nsel = w; ncnt = 0;
        end else if (ncnt < MAX_HOLD - 1) begin
            ncnt = ncnt + 1;
        end
        m_h <= nh; m_ptr <= nptr; m_cnt <= ncnt; m_sel <= nsel; m_to <= nto;
    end

    always @(negedge clk_in) begin : compare
        logic [3:0] eg;
        logic       ev;
        if (cmp_en) begin
            ev = (m_h >= 0);
            eg = ev ? 4'(1 << m_h) : 4'b0000;
            chk("cmp_gnt",   gnt_out, eg);
            chk("cmp_sel",   {2'b00, sel_out}, 4'(m_sel));
            chk("cmp_valid", {3'b000, valid_out}, {3'b000, ev});
            chk("cmp_y",     {3'b000, y_out}, {3'b000, ev & data_in[m_sel]});
            chk("cmp_to",    {3'b000, timeout_out}, {3'b000, m_to});
        end
    end

    // Inputs change 2 time units after the rising edge. This keeps them
    // clear of both the sampling edge and the falling-edge compare.
    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk_in);
        #2;
    endtask

    int         rot_order [4] = '{1, 2, 3, 0};
    logic [3:0] one = 4'b0001;
    logic [3:0] vec_req  [12] = '{4'b1010, 4'b1010, 4'b0010, 4'b0110, 4'b0100, 4'b1101,
                                  4'b1001, 4'b0001, 4'b0000, 4'b1111, 4'b0111, 4'b0011};
    logic [3:0] vec_data [12] = '{4'b1000, 4'b0010, 4'b1111, 4'b0100, 4'b0000, 4'b1001,
                                  4'b0110, 4'b0001, 4'b1111, 4'b1010, 4'b0101, 4'b1100};

    initial begin
        int h;
        // Reset with every request set
        rst_in = 1'b1; req_in = 4'b1111; data_in = 4'b1111;
        tick();
        cmp_en = 1'b1;
        tick();
        chk("rst_gnt",   gnt_out, 4'b0000);
        chk("rst_sel",   {2'b00, sel_out}, 4'd0);
        chk("rst_valid", {3'b000, valid_out}, 4'd0);
        chk("rst_y",     {3'b000, y_out}, 4'd0);

        // Single request
        rst_in = 1'b0; req_in = 4'b0100; data_in = 4'b0100;
        tick();
        chk("single_gnt", gnt_out, 4'b0100);
        chk("single_sel", {2'b00, sel_out}, 4'd2);
        chk("single_y",   {3'b000, y_out}, 4'd1);
        req_in = 4'b0000;
        tick();
        chk("single_drop_gnt",   gnt_out, 4'b0000);
        chk("single_drop_valid", {3'b000, valid_out}, 4'd0);

        // Rotation 0,1,2,3,0 with no idle cycles
        rst_in = 1'b1; tick(); rst_in = 1'b0;
        req_in = 4'b1111; data_in = 4'b0101;
        tick();
        chk("rot_first", gnt_out, 4'b0001);
        h = 0;
        for (int i = 0; i < 4; i++) begin
            req_in = 4'b1111 & ~(one << h);
            tick();
            chk("rot_gnt",   gnt_out, one << rot_order[i]);
            chk("rot_valid", {3'b000, valid_out}, 4'd1);
            h = rot_order[i];
        end

        // Wrap and handover from holder 3 to requester 0
        req_in = 4'b1000;
        tick();
        chk("wrap_hold3", gnt_out, 4'b1000);
        req_in = 4'b1001;
        tick();
        chk("wrap_keep3", gnt_out, 4'b1000);
        req_in = 4'b0001;
        tick();
        chk("wrap_gnt0", gnt_out, 4'b0001);
        chk("wrap_sel0", {2'b00, sel_out}, 4'd0);

        // Hold limit with two requesters, then with one
        rst_in = 1'b1; tick(); rst_in = 1'b0;
        req_in = 4'b0011; data_in = 4'b0011;
        tick();
        chk("to_first", gnt_out, 4'b0001);
        tick(7);
        chk("to_pre_gnt", gnt_out, 4'b0001);
        chk("to_pre_to",  {3'b000, timeout_out}, 4'd0);
        tick();
        chk("to_gnt",   gnt_out, TO_EN ? 4'b0010 : 4'b0001);
        chk("to_pulse", {3'b000, timeout_out}, {3'b000, TO_EN});
        tick();
        chk("to_pulse_end", {3'b000, timeout_out}, 4'd0);
        req_in = 4'b0001;
        tick();
        chk("alone_gnt", gnt_out, 4'b0001);
        tick(7);
        chk("alone_pre_to", {3'b000, timeout_out}, 4'd0);
        tick();
        chk("alone_gnt2",  gnt_out, 4'b0001);
        chk("alone_pulse", {3'b000, timeout_out}, {3'b000, TO_EN});
        tick(7);
        chk("alone_gap",   {3'b000, timeout_out}, 4'd0);
        tick();
        chk("alone_pulse2", {3'b000, timeout_out}, {3'b000, TO_EN});

        // Reset during a grant
        rst_in = 1'b1; tick(); rst_in = 1'b0;
        req_in = 4'b0010; data_in = 4'b0011;
        tick();
        chk("midrst_hold1", gnt_out, 4'b0010);
        chk("midrst_sel1",  {2'b00, sel_out}, 4'd1);
        rst_in = 1'b1;
        tick();
        chk("midrst_gnt",   gnt_out, 4'b0000);
        chk("midrst_sel",   {2'b00, sel_out}, 4'd0);
        chk("midrst_valid", {3'b000, valid_out}, 4'd0);
        chk("midrst_y",     {3'b000, y_out}, 4'd0);
        rst_in = 1'b0; req_in = 4'b0011;
        tick();
        chk("midrst_after", gnt_out, 4'b0001);

        // Mixed vectors, checked against the model only
        for (int i = 0; i < 12; i++) begin
            req_in = vec_req[i]; data_in = vec_data[i];
            tick();
        end
        req_in = 4'b0000;
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
